// File: rtl/hcm_if.sv
// hcm_if: payload/sample bundle between the data source and hcm_transmitter.
// The master drives the parallel payload; the slave (transmitter) returns samples and ready.
interface hcm_if #(
    parameter int unsigned HADAMARD      = 16,
    parameter int unsigned PAM_LEVEL_LOG = 3,
    parameter int unsigned BIT_NUM       = 7
);
    localparam int unsigned N = (HADAMARD - 1) * PAM_LEVEL_LOG;
    localparam int unsigned M = BIT_NUM * HADAMARD;

    logic [N-1:0] input_data;
    logic [M-1:0] output_data;
    logic         ready;

    modport master (output input_data, input output_data, input ready);
    modport slave  (input input_data, output output_data, output ready);
endinterface

// File: rtl/hcm_transmitter.sv
// hcm_transmitter: bit-serial Hadamard-coded PAM transmitter.
// Splits the payload into HADAMARD-1 PAM symbols (d_0 = 0), multiplies by the
// unipolar Sylvester Hadamard matrix one input bit per clock, and presents
// HADAMARD intensity samples. Optional build macro HCM_OUTPUT_GATE_EN holds
// output_data at zero until the final samples are ready.
// The bus interface must be instantiated with the same parameters as this module.
module hcm_transmitter #(
    parameter int unsigned HADAMARD      = 16,
    parameter int unsigned PAM_LEVEL_LOG = 3,
    parameter int unsigned BIT_NUM       = 7,
    parameter int unsigned MIDLE_BITS    = 11
) (
    input  logic   clk,
    input  logic   resetn,   // active-high synchronous reset
    hcm_if.slave   bus
);
    localparam int unsigned N  = (HADAMARD - 1) * PAM_LEVEL_LOG;
    localparam int unsigned M  = BIT_NUM * HADAMARD;
    localparam int unsigned HW = (HADAMARD > 1) ? $clog2(HADAMARD) : 1;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned PW = (PAM_LEVEL_LOG > 1) ? $clog2(PAM_LEVEL_LOG) : 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    logic [0:0]            r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt,   w_cnt_nxt;    // input bit index i
    logic [HW-1:0]         r_sym,   w_sym_nxt;    // symbol index k = i/L + 1
    logic [PW-1:0]         r_pos,   w_pos_nxt;    // bit weight b = i mod L
    logic [MIDLE_BITS-1:0] r_acc [HADAMARD];
    logic [MIDLE_BITS-1:0] w_acc_nxt [HADAMARD];
    logic [M-1:0]          r_out,   w_out_nxt;
    logic                  r_ready, w_ready_nxt;
    logic                  w_bit;
    logic [MIDLE_BITS-1:0] w_term;

    // Next-state, accumulation and output selection
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sym_nxt   = r_sym;
        w_pos_nxt   = r_pos;
        w_ready_nxt = r_ready;
        w_bit       = 1'b0;
        w_term      = '0;
        w_out_nxt   = '0;
        for (int n = 0; n < HADAMARD; n++) begin
            w_acc_nxt[n] = r_acc[n];
        end

        if (r_state == ST_RUN) begin
            w_bit  = bus.input_data[r_cnt];
            w_term = MIDLE_BITS'(w_bit) << r_pos;
            // Hb[n][k] = 1 when n & k has even parity
            for (int n = 0; n < HADAMARD; n++) begin
                if (~^(HW'(n) & r_sym)) begin
                    w_acc_nxt[n] = r_acc[n] + w_term;
                end
            end
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_pos == PW'(PAM_LEVEL_LOG - 1)) begin
                w_pos_nxt = '0;
                w_sym_nxt = r_sym + HW'(1);
            end else begin
                w_pos_nxt = r_pos + PW'(1);
            end
            if (r_cnt == CW'(N - 1)) begin
                w_state_nxt = ST_DONE;
                w_ready_nxt = 1'b1;
            end
        end

        for (int n = 0; n < HADAMARD; n++) begin
            w_out_nxt[n*BIT_NUM +: BIT_NUM] = BIT_NUM'(w_acc_nxt[n]);
        end
`ifdef HCM_OUTPUT_GATE_EN
        if (!w_ready_nxt) begin
            w_out_nxt = '0;
        end
`endif
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_sym   <= HW'(1);
            r_pos   <= '0;
            r_ready <= 1'b0;
            r_out   <= '0;
            for (int n = 0; n < HADAMARD; n++) begin
                r_acc[n] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sym   <= w_sym_nxt;
            r_pos   <= w_pos_nxt;
            r_ready <= w_ready_nxt;
            r_out   <= w_out_nxt;
            for (int n = 0; n < HADAMARD; n++) begin
                r_acc[n] <= w_acc_nxt[n];
            end
        end
    end

    assign bus.output_data = r_out;
    assign bus.ready       = r_ready;
endmodule

// File: tb/tb_hcm_transmitter.sv
// tb_hcm_transmitter: randomized self-checking bench for hcm_transmitter,
// compared against a direct matrix-product model x = Hb * d.
module tb_hcm_transmitter;
    localparam int unsigned HADAMARD      = 16;
    localparam int unsigned PAM_LEVEL_LOG = 3;
    localparam int unsigned BIT_NUM       = 7;
    localparam int unsigned MIDLE_BITS    = 11;
    localparam int unsigned N = (HADAMARD - 1) * PAM_LEVEL_LOG;
    localparam int unsigned M = BIT_NUM * HADAMARD;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_pass;

    hcm_if #(.HADAMARD(HADAMARD), .PAM_LEVEL_LOG(PAM_LEVEL_LOG), .BIT_NUM(BIT_NUM)) bus ();

    hcm_transmitter #(
        .HADAMARD(HADAMARD), .PAM_LEVEL_LOG(PAM_LEVEL_LOG),
        .BIT_NUM(BIT_NUM), .MIDLE_BITS(MIDLE_BITS)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Golden samples: d_0 = 0, d_k from payload, x_n = sum of d_k where popcount(n&k) even
    function automatic logic [M-1:0] golden(input logic [N-1:0] v);
        logic [M-1:0] r;
        int s;
        int d;
        r = '0;
        for (int n = 0; n < HADAMARD; n++) begin
            s = 0;
            for (int k = 1; k < HADAMARD; k++) begin
                d = 0;
                for (int b = 0; b < PAM_LEVEL_LOG; b++)
                    if (v[(k-1)*PAM_LEVEL_LOG + b]) d += (1 << b);
                if (($countones(n & k) % 2) == 0) s += d;
            end
            r[n*BIT_NUM +: BIT_NUM] = BIT_NUM'(s);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] rand_vec();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return N'(t);
    endfunction

    // Assert reset for one edge and check cleared outputs
    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_out", bus.output_data, '0);
        check("rst_rdy", bus.ready, '0);
    endtask

    // Release reset and run ncyc edges; inputs change after DONE must be ignored
    task automatic run_cycles(input logic [N-1:0] data, input int ncyc, input string tag);
        logic [N-1:0] m;
        logic [M-1:0] exp_out;
        bus.input_data = data;
        resetn = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            m = '0;
            for (int j = 0; j < N; j++) if (j < c) m[j] = 1'b1;
`ifdef HCM_OUTPUT_GATE_EN
            exp_out = (c >= N) ? golden(data) : '0;
`else
            exp_out = golden(data & m);
`endif
            check({tag, "_rdy"}, bus.ready, (c >= N) ? 1 : 0);
            check({tag, "_out"}, bus.output_data, exp_out);
            if (c >= N) bus.input_data = rand_vec();
        end
    endtask

    logic [N-1:0] v;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        resetn   = 1'b1;
        bus.input_data = '0;

        do_reset();
        run_cycles('0, N, "zero");

        do_reset();
        v = '1;
        run_cycles(v, N, "ones");
        check("ones_x0", bus.output_data[BIT_NUM-1:0], 105);
        check("ones_x1", bus.output_data[2*BIT_NUM-1:BIT_NUM], 49);
        check("ones_x15", bus.output_data[M-1:M-BIT_NUM], 49);

        do_reset();
        v = N'(1);
        run_cycles(v, N, "one");
        check("one_x0", bus.output_data[BIT_NUM-1:0], 1);
        check("one_x1", bus.output_data[2*BIT_NUM-1:BIT_NUM], 0);

        do_reset();
        run_cycles(rand_vec(), N + 20, "hold");

        do_reset();
        run_cycles(rand_vec(), 20, "abort");
        do_reset();
        run_cycles(rand_vec(), N, "rerun");

        for (int t = 0; t < 100; t++) begin
            do_reset();
            run_cycles(rand_vec(), N, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
